// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C blocks.
//   state_t   transaction sequencer states
//   PH_*      the four quarter-period phases of one bit slot
//   ADDR_W / DATA_W  address and data widths
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    AACK,
    DATA,
    DACK,
    STOP
  } state_t;

  // Phase index inside one bit slot: SCL low for the first half, high for
  // the second half. SDA changes only at LO0, is sampled entering HI1.
  localparam logic [1:0] PH_SCL_LO0 = 2'd0;
  localparam logic [1:0] PH_SCL_LO1 = 2'd1;
  localparam logic [1:0] PH_SCL_HI0 = 2'd2;
  localparam logic [1:0] PH_SCL_HI1 = 2'd3;

endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: free-running divider producing a one-cycle tick every
// CLK_DIV enabled clocks.
//   clk, rst_n  clock, async active-low reset
//   en          count enable (counter frozen when low)
//   clr         synchronous clear, wins over en
//   tick        one-cycle pulse on the last count of each period
module i2c_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && !clr && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= tick ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master. One request = START, addr+R/W, ACK,
// one data byte, ACK/NACK, STOP.
//   clk, rst_n        system clock, async active-low reset
//   start, rw, addr, wdata   request; captured only when accepted (busy=0)
//   busy              high from accept through the done cycle
//   done              one-cycle completion pulse
//   ack_err           address or write-data NACK seen (valid with done)
//   rdata             received byte (valid with done for reads)
//   scl, sda          I2C pins; sda is open-drain
// Macro I2C_CLK_STRETCH_EN: scl becomes open-drain and is read back through a
// 2-flop synchroniser; each slot holds at phase 2 until scl is seen high.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  output logic [DATA_W-1:0] rdata,
  inout  wire               scl,
  inout  wire               sda
);

  state_t              state, state_d;
  logic [1:0]          ph;
  logic [2:0]          bitcnt;
  logic [DATA_W-1:0]   tx_sh, rx_sh, wdata_q;
  logic                rw_q, nack_q, fin;
  logic                tick, div_en, div_clr, wait_hi;
  logic                scl_hi, sda_lo, sda_in;
  logic                acc, sample, slot_end, last_bit;

  assign acc      = start && !busy;
  assign sample   = tick && (ph == PH_SCL_HI0);   // edge into HI1
  assign slot_end = tick && (ph == PH_SCL_HI1);
  assign last_bit = (bitcnt == 3'd7);
  // SDA has been stable for a full quarter period when sampled, so it is
  // used directly rather than through a synchroniser.
  assign sda_in   = sda;

  assign div_en  = busy && (state != IDLE) && !wait_hi;
  assign div_clr = acc || wait_hi;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en),
    .clr   (div_clr),
    .tick  (tick)
  );

  // Sequencer next state
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (acc)                  state_d = START;
      START:   if (slot_end)             state_d = ADDR;
      ADDR:    if (slot_end && last_bit) state_d = AACK;
      AACK:    if (slot_end)             state_d = nack_q ? STOP : DATA;
      DATA:    if (slot_end && last_bit) state_d = DACK;
      DACK:    if (slot_end)             state_d = STOP;
      STOP:    if (slot_end)             state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Pin levels, decoded from state/phase. Reset forces IDLE, so the bus is
  // released in the same cycle rst_n falls.
  always_comb begin
    scl_hi = 1'b1;
    sda_lo = 1'b0;
    case (state)
      START: begin
        scl_hi = (ph != PH_SCL_HI1);
        sda_lo = ph[1];
      end
      ADDR: begin
        scl_hi = ph[1];
        sda_lo = !tx_sh[DATA_W-1];
      end
      DATA: begin
        scl_hi = ph[1];
        sda_lo = !rw_q && !tx_sh[DATA_W-1];
      end
      AACK, DACK: scl_hi = ph[1];
      STOP: begin
        scl_hi = ph[1];
        sda_lo = (ph != PH_SCL_HI1);
      end
      default: ;
    endcase
  end

  assign sda = sda_lo ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ph      <= PH_SCL_LO0;
      bitcnt  <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      nack_q  <= 1'b0;
      fin     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_d;
      // STOP ends -> fin for one cycle -> done; busy covers the done cycle
      // so a start coinciding with done is not taken.
      fin   <= 1'b0;
      done  <= fin;

      if (acc) begin
        busy    <= 1'b1;
        ph      <= PH_SCL_LO0;
        bitcnt  <= '0;
        tx_sh   <= {addr, rw};
        wdata_q <= wdata;
        rw_q    <= rw;
        nack_q  <= 1'b0;
        ack_err <= 1'b0;
      end else if (done) begin
        busy <= 1'b0;
      end

      if (tick) ph <= ph + 2'd1;

      if (sample) begin
        case (state)
          AACK: if (sda_in) begin
            nack_q  <= 1'b1;
            ack_err <= 1'b1;
          end
          DACK: if (sda_in && !rw_q) ack_err <= 1'b1;
          DATA: rx_sh <= {rx_sh[DATA_W-2:0], sda_in};
          default: ;
        endcase
      end

      if (slot_end) begin
        case (state)
          ADDR, DATA: begin
            tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
            bitcnt <= bitcnt + 3'd1;
          end
          AACK: tx_sh <= wdata_q;
          STOP: begin
            fin <= 1'b1;
            if (rw_q && !nack_q) rdata <= rx_sh;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef I2C_CLK_STRETCH_EN
  logic [1:0] scl_sync;

  assign scl = scl_hi ? 1'bz : 1'b0;

  // Entering HI0 the divider is parked until the released scl is actually
  // seen high; the divider then restarts so HI0 keeps its full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      wait_hi  <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      if (tick && (ph == PH_SCL_LO1)) wait_hi <= 1'b1;
      else if (wait_hi && scl_sync[1]) wait_hi <= 1'b0;
    end
  end
`else
  assign scl     = scl_hi;
  assign wait_hi = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_master.sv
`timescale 1ns/1ps
module tb_i2c_master;

  localparam int C = 4;
  localparam logic [6:0] OWN = 7'h2A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, ack_err;
  logic [7:0] rdata;
  wire        scl, sda;

  int checks = 0;
  int errors = 0;

  // slave / bus monitor state
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_RACK, S_SKIP} sst_t;
  sst_t        ss = S_IDLE;
  logic        s_drv = 1'b0;
  logic        p_scl = 1'b1, p_sda = 1'b1;
  int          sc = 0;
  logic [7:0]  ssh = '0, data_out = '0, rbyte = 8'h55;
  logic        s_rd = 1'b0;
  logic [31:0] mon = '0;
  int          mon_n = 0, starts = 0, stops = 0;
  logic [7:0]  erd = '0;

  pullup (sda);
  assign sda = s_drv ? 1'b0 : 1'bz;

`ifdef I2C_CLK_STRETCH_EN
  logic s_hold = 1'b0;
  int   hold_cnt = 0;
  pullup (scl);
  assign scl = s_hold ? 1'b0 : 1'bz;
`endif

  i2c_master #(.CLK_DIV(C)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .rdata   (rdata),
    .scl     (scl),
    .sda     (sda)
  );

  always #5 clk = ~clk;

  // Behavioural slave at own address OWN plus bus monitor, sampled on the
  // falling system clock edge. Records every bit seen on an SCL rise.
  always @(negedge clk) begin
`ifdef I2C_CLK_STRETCH_EN
    if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
      if (hold_cnt == 1) s_hold <= 1'b0;
    end
`endif
    if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b1 && sda === 1'b0) begin
      ss <= S_ADDR; sc <= 0; ssh <= '0; s_drv <= 1'b0;
      mon <= '0; mon_n <= 0; starts <= starts + 1;
    end else if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b0 && sda === 1'b1) begin
      ss <= S_IDLE; s_drv <= 1'b0; stops <= stops + 1;
    end else if (p_scl !== 1'b1 && scl === 1'b1) begin
      mon   <= {mon[30:0], sda === 1'b1};
      mon_n <= mon_n + 1;
      if (ss == S_ADDR || ss == S_WR) begin
        ssh <= {ssh[6:0], sda === 1'b1};
        sc  <= sc + 1;
      end else if (ss == S_RD) begin
        sc <= sc + 1;
      end
    end else if (p_scl === 1'b1 && scl !== 1'b1) begin
      case (ss)
        S_ADDR: if (sc == 8) begin
          s_rd <= ssh[0];
          if (ssh[7:1] == OWN) begin
            ss <= S_AACK; s_drv <= 1'b1;
`ifdef I2C_CLK_STRETCH_EN
            s_hold <= 1'b1; hold_cnt <= 2*C + 10;
`endif
          end else ss <= S_SKIP;
        end
        S_AACK: begin
          sc <= 0;
          if (s_rd) begin ss <= S_RD; s_drv <= ~rbyte[7]; end
          else      begin ss <= S_WR; s_drv <= 1'b0; end
        end
        S_RD: if (sc == 8) begin s_drv <= 1'b0; ss <= S_RACK; end
              else s_drv <= ~rbyte[7-sc];
        S_WR: if (sc == 8) begin data_out <= ssh; s_drv <= 1'b1; ss <= S_WACK; end
        S_WACK: begin s_drv <= 1'b0; ss <= S_SKIP; end
        S_RACK: ss <= S_SKIP;
        default: ;
      endcase
    end
    p_scl <= scl;
    p_sda <= sda;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outcome from the bus protocol rules: bits seen on each SCL rise
  // (addr, R/W, ACK, data, ACK/NACK, STOP rise) and done latency.
  function automatic void model(input logic [6:0] a, input logic r, input logic [7:0] w,
                                input logic [7:0] rb, output int lat, output logic ae,
                                output logic [31:0] bits, output int nb);
    if (a != OWN) begin
      lat = 44*C + 1; ae = 1'b1; nb = 10;
      bits = 32'({a, r, 1'b1, 1'b0});
    end else begin
      lat = 80*C + 1; ae = 1'b0; nb = 19;
      bits = 32'({a, r, 1'b0, (r ? rb : w), r, 1'b0});
    end
  endfunction

  task automatic accept();
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_accept", busy, 1);
    addr  = 7'($urandom);
    rw    = 1'($urandom);
    wdata = 8'($urandom);
  endtask

  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] w);
    addr = a; rw = r; wdata = w; start = 1'b1;
    accept();
  endtask

  task automatic finish(input logic [6:0] a, input logic r, input logic [7:0] w, input bit noise,
                        input bit chain, input logic [6:0] na, input logic nr, input logic [7:0] nw);
    int lat, nb, k, nz, st0, sp0;
    logic ae;
    logic [31:0] eb;
    bit seen;
    model(a, r, w, rbyte, lat, ae, eb, nb);
    st0 = starts; sp0 = stops;
    nz = $urandom_range(lat - 10, 3);
    seen = 0; k = 0;
    while (!seen && k < lat + 200) begin
      @(posedge clk); #1;
      k++;
      start = noise && (k == nz);
      seen = done;
    end
`ifdef I2C_CLK_STRETCH_EN
    chk("latency_min", k >= lat, 1);
    chk("latency_max", k <= lat + 150, 1);
`else
    chk("latency", k, lat);
`endif
    chk("ack_err", ack_err, ae);
    if (r && !ae) erd = rbyte;
    chk("rdata", rdata, erd);
    chk("busy_on_done", busy, 1);
    if (chain) begin
      start = 1'b1; addr = na; rw = nr; wdata = nw;
    end
    @(posedge clk); #1;
    chk("busy_after", busy, 0);
    chk("done_single", done, 0);
    chk("ack_hold", ack_err, ae);
    chk("bit_count", mon_n, nb);
    chk("bus_bits", mon, eb);
    chk("start_cond", starts - st0, 1);
    chk("stop_cond", stops - sp0, 1);
    if (!r && !ae) chk("slave_data", data_out, w);
  endtask

  task automatic txn(input logic [6:0] a, input logic r, input logic [7:0] w, input bit noise);
    issue(a, r, w);
    finish(a, r, w, noise, 0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [6:0] ra;
    logic       rr;
    logic [7:0] rwd;
    int         nd;

    #2 rst_n = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // directed: write, address NACK, read
    txn(OWN, 1'b0, 8'hA5, 1'b0);
    txn(7'h11, 1'b0, 8'h3C, 1'b0);
    rbyte = 8'h55;
    txn(OWN, 1'b1, 8'h00, 1'b0);

    // randomized, with ignored start pulses while busy
    for (int i = 0; i < 6; i++) begin
      ra    = ($urandom_range(0, 2) == 0) ? 7'($urandom) : OWN;
      rr    = 1'($urandom);
      rwd   = 8'($urandom);
      rbyte = 8'($urandom);
      txn(ra, rr, rwd, 1'b1);
    end

    // start on the done cycle is ignored, held one more cycle it is taken
    rbyte = 8'h96;
    issue(OWN, 1'b0, 8'hC3);
    finish(OWN, 1'b0, 8'hC3, 1'b0, 1'b1, OWN, 1'b1, 8'h00);
    accept();
    finish(OWN, 1'b1, 8'h00, 1'b0, 0, '0, 1'b0, '0);

    // reset inside DATA bit 3 of a write
    issue(OWN, 1'b0, 8'h0F);
    repeat (53*C) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_scl", scl, 1);
    chk("abort_sda", sda, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rdata", rdata, 0);
    erd = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    nd = 0;
    repeat (60*C) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);

    rbyte = 8'h3A;
    txn(OWN, 1'b1, 8'h00, 1'b0);
    txn(OWN, 1'b0, 8'h5E, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-byte I2C bus master that drives the team's i2c_slave over the shared scl/sda wires.
- Runs one transaction per request: START, 7-bit address plus R/W, ACK slot, one data byte, ACK/NACK slot, STOP.
- Sits between a register/command interface (system clock domain) and the physical I2C pins.

Parameters:
- CLK_DIV, 25: system clock cycles per quarter SCL period (SCL = f_clk / (4*CLK_DIV)); minimum 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only when busy=0
- rw  input  1  0 = write, 1 = read; captured with start
- addr  input  7  target slave address; captured with start
- wdata  input  8  write byte; captured with start
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse at end of transaction
- ack_err  output  1  valid with done; 1 = address or write-data NACK
- rdata  output  8  read byte; valid with done when rw=1
- scl  inout  1  I2C clock (see optional feature for drive style)
- sda  inout  1  I2C data, open-drain: driven 0 or released to z; external pull-up required

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, ack_err=0, rdata=8'h00; scl driven high (released under the macro); sda released; divider cleared.
- Divider: a counter produces a one-cycle tick every CLK_DIV clocks while busy. The phase counter (0..3) advances on each tick. Each bit slot has four phases:
  - ph0: SCL low, SDA updated
  - ph1: SCL low
  - ph2: SCL high
  - ph3: SCL high, SDA sampled on entry
- States: IDLE -> START -> ADDR (8 slots: addr[6:0] MSB first, then rw) -> AACK -> DATA (8 slots) -> DACK -> STOP -> IDLE.
- START: SCL high with SDA released for ph0-1. SDA driven low at ph2 while SCL stays high. SCL low at ph3.
- AACK: SDA released; sampled SDA=1 sets ack_err and jumps to STOP, skipping DATA/DACK.
- DATA write: master drives wdata MSB first, driving SDA low for 0 and releasing it for 1.
- DATA read: SDA released; sampled bits shifted into rdata MSB first.
- DACK:
  - Write: SDA released; sampled 1 sets ack_err.
  - Read: master releases SDA (NACK) to end the read.
- STOP: SDA low in ph0-1, SCL high at ph2, SDA released at ph3. Next cycle: done=1 for one clock, busy=0.
- Latency, no stretch: done asserts exactly 80*CLK_DIV+1 clocks after the start-accept edge (20 slots x 4 phases). The address-NACK path takes 44*CLK_DIV+1 clocks.
- start while busy=1 is ignored; inputs are captured only at accept.
- start on the same cycle as done is ignored (busy still 1 on that edge); accepted on the following cycle.
- ack_err and rdata hold until the next accepted start, which clears ack_err.
- rst_n low mid-transaction aborts immediately with no STOP generated. Bus returns to released/idle and no done pulse is produced.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined:
  - scl is open-drain: driven 0, otherwise z.
  - On entering ph2 of any slot, the phase counter holds until scl reads 1, synchronised through 2 flops, so a slave can stretch the clock.
  - The divider restarts when release is seen.
- Undefined: scl is driven push-pull 0/1 and never read back; latency is fixed as above.

Decomposition:
- Shared package i2c_pkg holds:
  - state enum (IDLE, START, ADDR, AACK, DATA, DACK, STOP)
  - phase constants PH_SCL_LO0, PH_SCL_LO1, PH_SCL_HI0, PH_SCL_HI1
  - ADDR_W=7, DATA_W=8
- Sub-module i2c_tick_gen: CLK_DIV counter with enable and synchronous clear, outputs the tick pulse. Reused by future I2C blocks.

Test Plan:
- Write, acking slave (own_addr=7'h2A), CLK_DIV=4, addr=7'h2A, rw=0, wdata=8'hA5:
  - Bus carries START, 0x54, ACK, 0xA5, ACK, STOP.
  - done at clock 321 after accept, ack_err=0, slave data_out=8'hA5.
- Address NACK, addr=7'h11 with no matching slave:
  - ack_err=1 with done at 44*CLK_DIV+1.
  - No DATA clocks appear on scl.
- Read, slave returning 8'h55, rw=1:
  - rdata=8'h55, ack_err=0.
  - Master leaves SDA released in DACK (NACK), then STOP.
- start pulsed while busy, and on the done cycle:
  - Both ignored; exactly one transaction observed.
  - A start the cycle after done is accepted.
- Reset mid-transaction: rst_n low during DATA bit 3:
  - scl/sda released within the same cycle, busy=0, no done.
  - A next transaction completes normally.
- With I2C_CLK_STRETCH_EN, slave model holds scl low 10 clocks in AACK:
  - Master waits; done delayed by 10 plus synchroniser clocks; data intact.
